rec_tran: RTL and testbench

- Receive-side ARQ responder at the far end of the OTN link from the sender's transmit/retransmit block.
- Takes the byte stream arriving from the link and hunts for frame alignment (FAS). Captures the sequence byte and payload, then checks the XOR parity byte.
- Returns a per-frame ACK/NACK to the sender.
- Good frames go through a two-bank ping-pong buffer and are forwarded to the demapper as a valid/ready byte stream.

---
 rtl/otn_arq_pkg.sv | 24 ++
 rtl/rec_pingpong_buf.sv | 88 ++++++++
 rtl/rec_tran.sv | 161 ++++++++++++++++
 tb/tb_rec_tran.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otn_arq_pkg.sv
// rtl/otn_arq_pkg.sv - FAS constants, receive-state and bank-state types shared by the OTN ARQ blocks
package otn_arq_pkg;

    localparam logic [7:0] FAS_F6 = 8'hF6;
    localparam logic [7:0] FAS_28 = 8'h28;
    localparam int FAS_LEN = 6;
    localparam logic [8*FAS_LEN-1:0] FAS_PATTERN =
        {FAS_F6, FAS_F6, FAS_F6, FAS_28, FAS_28, FAS_28};

    typedef enum logic [2:0] {
        RX_HUNT,
        RX_SEQ,
        RX_PAY,
        RX_CHK,
        RX_RESP
    } rx_state_t;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILL,
        BANK_FULL
    } bank_state_t;

endpackage

// File: rtl/rec_pingpong_buf.sv
// rtl/rec_pingpong_buf.sv - two-bank payload buffer drained in fill order as a valid/ready byte stream
module rec_pingpong_buf
    import otn_arq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              claim,
    input  logic              commit,
    input  logic              abort,
    output logic              wr_ok,
    output logic [7:0]        data,
    output logic              valid,
    input  logic              ready,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [7:0]        mem [2][DEPTH];
    bank_state_t       bank_st [2];
    logic              wr_bank;
    logic              rd_bank;
    logic              out_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              free;
    logic              fetch;

    assign free  = valid && last && ready;
    // The output register doubles as the RAM read register, so a load happens whenever it empties.
    assign fetch = (!valid || ready) && (bank_st[rd_bank] == BANK_FULL);
    // A bank released by this cycle's final handshake is already usable by the writer.
    assign wr_ok = (bank_st[wr_bank] == BANK_EMPTY) || (free && (out_bank == wr_bank));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            out_bank   <= 1'b0;
            rd_addr    <= '0;
            data       <= '0;
            valid      <= 1'b0;
            last       <= 1'b0;
        end else begin
            if (free) begin
                bank_st[out_bank] <= BANK_EMPTY;
            end
            if (claim) begin
                bank_st[wr_bank] <= BANK_FILL;
            end
            if (commit) begin
                bank_st[wr_bank] <= BANK_FULL;
                wr_bank          <= !wr_bank;
            end else if (abort) begin
                bank_st[wr_bank] <= BANK_EMPTY;
            end
            if (fetch) begin
                data     <= mem[rd_bank][rd_addr];
                valid    <= 1'b1;
                last     <= (rd_addr == LAST_ADDR);
                out_bank <= rd_bank;
                if (rd_addr == LAST_ADDR) begin
                    rd_addr <= '0;
                    rd_bank <= !rd_bank;
                end else begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                end
            end else if (ready) begin
                valid <= 1'b0;
                last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rec_tran.sv
// rtl/rec_tran.sv - OTN ARQ receive responder: FAS hunt, XOR parity check, ACK/NACK, ping-pong forward
// Define REC_TRAN_DUP_DROP_EN to ACK but discard a good frame repeating the last accepted seq.
module rec_tran
    import otn_arq_pkg::*;
#(
    parameter int PAYLOAD_BYTES = 16,
    parameter int ADDR_W        = $clog2(PAYLOAD_BYTES)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_otn_rx_data,
    input  logic       i_otn_rx_valid,
    input  logic       i_arq_en,
    output logic       o_otn_tx_ack,
    output logic       o_otn_tx_nack,
    output logic [7:0] o_frame_data,
    output logic       o_frame_data_valid,
    input  logic       i_frame_data_ready,
    output logic       o_frame_data_last,
    output logic       o_locked,
    output logic       o_drop
);

    localparam int SR_W = 8 * (FAS_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(PAYLOAD_BYTES - 1);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [SR_W-1:0]   hunt_sr;
    logic [7:0]        par_acc;
    logic [ADDR_W-1:0] cnt;
    logic              ovf;
    logic              par_ok;
    logic              fas_hit;
    logic              good;
    logic              dup;
    logic              claim;
    logic              commit;
    logic              abort;
    logic              wr_en;
    logic              wr_ok;

    assign fas_hit = ({hunt_sr, i_otn_rx_data} == FAS_PATTERN);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= RX_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_HUNT: if (i_otn_rx_valid && fas_hit) state_nxt = RX_SEQ;
            RX_SEQ:  if (i_otn_rx_valid) state_nxt = RX_PAY;
            RX_PAY:  if (i_otn_rx_valid && (cnt == LAST_CNT)) state_nxt = RX_CHK;
            RX_CHK:  if (i_otn_rx_valid) state_nxt = RX_RESP;
            default: state_nxt = RX_HUNT;
        endcase
    end

    // The hunt window is cleared on lock, so bytes seen while locked can never complete a match.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hunt_sr <= '0;
            par_acc <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            par_ok  <= 1'b0;
        end else if (i_otn_rx_valid) begin
            case (state)
                RX_HUNT: hunt_sr <= fas_hit ? '0 : {hunt_sr[SR_W-9:0], i_otn_rx_data};
                RX_RESP: hunt_sr <= {hunt_sr[SR_W-9:0], i_otn_rx_data};
                RX_SEQ: begin
                    par_acc <= i_otn_rx_data;
                    cnt     <= '0;
                    ovf     <= !wr_ok;
                end
                RX_PAY: begin
                    par_acc <= par_acc ^ i_otn_rx_data;
                    cnt     <= cnt + ADDR_W'(1);
                end
                RX_CHK: par_ok <= (i_otn_rx_data == par_acc);
                default: ;
            endcase
        end
    end

`ifdef REC_TRAN_DUP_DROP_EN
    logic [7:0] seq;
    logic [7:0] last_seq;
    logic       last_seq_vld;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            seq          <= '0;
            last_seq     <= '0;
            last_seq_vld <= 1'b0;
        end else begin
            if ((state == RX_SEQ) && i_otn_rx_valid) begin
                seq <= i_otn_rx_data;
            end
            if ((state == RX_RESP) && good) begin
                last_seq     <= seq;
                last_seq_vld <= 1'b1;
            end
        end
    end

    assign dup = last_seq_vld && (last_seq == seq);
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        good          = par_ok && !ovf;
        o_locked      = (state == RX_SEQ) || (state == RX_PAY) || (state == RX_CHK);
        o_otn_tx_ack  = 1'b0;
        o_otn_tx_nack = 1'b0;
        o_drop        = 1'b0;
        claim         = 1'b0;
        commit        = 1'b0;
        abort         = 1'b0;
        wr_en         = 1'b0;
        case (state)
            RX_SEQ: claim = i_otn_rx_valid && wr_ok;
            RX_PAY: wr_en = i_otn_rx_valid && !ovf;
            RX_RESP: begin
                o_otn_tx_ack  = i_arq_en && good;
                o_otn_tx_nack = i_arq_en && !good;
                o_drop        = !good;
                commit        = good && !dup;
                // An overflowed frame never owned a bank, so it must not release one.
                abort         = !ovf && !(good && !dup);
            end
            default: ;
        endcase
    end

    rec_pingpong_buf #(
        .DEPTH  (PAYLOAD_BYTES),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (wr_en),
        .wr_addr (cnt),
        .wr_data (i_otn_rx_data),
        .claim   (claim),
        .commit  (commit),
        .abort   (abort),
        .wr_ok   (wr_ok),
        .data    (o_frame_data),
        .valid   (o_frame_data_valid),
        .ready   (i_frame_data_ready),
        .last    (o_frame_data_last)
    );

endmodule

// File: tb/tb_rec_tran.sv
// tb/tb_rec_tran.sv - directed bench for rec_tran with a frame-level response and payload scoreboard
module tb_rec_tran;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       arq_en;
    logic       ack;
    logic       nack;
    logic [7:0] fdata;
    logic       fvalid;
    logic       fready;
    logic       flast;
    logic       locked;
    logic       drop;

    always #5 clk = !clk;

    rec_tran #(.PAYLOAD_BYTES(N)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_otn_rx_data      (rx_data),
        .i_otn_rx_valid     (rx_valid),
        .i_arq_en           (arq_en),
        .o_otn_tx_ack       (ack),
        .o_otn_tx_nack      (nack),
        .o_frame_data       (fdata),
        .o_frame_data_valid (fvalid),
        .i_frame_data_ready (fready),
        .o_frame_data_last  (flast),
        .o_locked           (locked),
        .o_drop             (drop)
    );

    int vectors = 0;
    int miscompares = 0;

    logic       chk_en = 1'b0;
    logic       exp_locked = 1'b0, exp_ack = 1'b0, exp_nack = 1'b0, exp_drop = 1'b0;
    logic       nxt_locked = 1'b0, nxt_ack = 1'b0, nxt_nack = 1'b0, nxt_drop = 1'b0;
    logic [8:0] exp_q[$];
    logic [7:0] out_log[$];
    int         stored = 0, drained = 0;
    int         ack_cnt = 0, nack_cnt = 0, drop_cnt = 0, byte_cnt = 0, last_cnt = 0;
    int         b_ack = 0, b_nack = 0, b_drop = 0, b_byte = 0;
    int         gap_ctr = 0;
    logic       stall = 1'b0;
    logic [7:0] hold_data;
    logic       hold_last;
    logic [7:0] last_seq = 8'h00;
    logic       last_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] par_of(input logic [7:0] seq, input logic [31:0] pay);
        logic [7:0] r = seq;
        for (int i = 0; i < N; i++) r ^= pay[31-8*i -: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            stall = 1'b0;
        end else if (chk_en) begin
            chk("ack", ack, exp_ack);
            chk("nack", nack, exp_nack);
            chk("drop", drop, exp_drop);
            chk("locked", locked, exp_locked);
            if (stall) begin
                chk("hold_valid", fvalid, 1);
                chk("hold_data", fdata, hold_data);
                chk("hold_last", flast, hold_last);
            end
            if (fvalid && fready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_byte: got %0h, expected no byte", fdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", fdata, e[7:0]);
                    chk("last", flast, e[8]);
                    if (e[8]) drained++;
                end
                out_log.push_back(fdata);
                byte_cnt++;
                if (flast) last_cnt++;
            end
            stall     = fvalid && !fready;
            hold_data = fdata;
            hold_last = flast;
            ack_cnt  += int'(ack);
            nack_cnt += int'(nack);
            drop_cnt += int'(drop);
        end
    end

    task automatic step(input logic [7:0] b, input logic v);
        @(posedge clk);
        #1;
        exp_locked = nxt_locked;
        exp_ack    = nxt_ack;
        exp_nack   = nxt_nack;
        exp_drop   = nxt_drop;
        nxt_ack    = 1'b0;
        nxt_nack   = 1'b0;
        nxt_drop   = 1'b0;
        rx_data    = b;
        rx_valid   = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 1'b0);
    endtask

    task automatic put(input logic [7:0] b, input bit gaps);
        if (gaps && (gap_ctr % 3 == 1)) step(8'h00, 1'b0);
        step(b, 1'b1);
        gap_ctr++;
    endtask

    task automatic send_fas(input bit gaps);
        for (int i = 0; i < 6; i++) put((i < 3) ? 8'hF6 : 8'h28, gaps);
        nxt_locked = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] seq, input logic [31:0] pay,
                              input logic [7:0] par, input bit gaps);
        bit ovf, good, dup;
        send_fas(gaps);
        ovf = (stored - drained) >= 2;
        put(seq, gaps);
        for (int i = 0; i < N; i++) put(pay[31-8*i -: 8], gaps);
        put(par, gaps);
        nxt_locked = 1'b0;
        good = (par == par_of(seq, pay)) && !ovf;
        dup  = 1'b0;
`ifdef REC_TRAN_DUP_DROP_EN
        dup = good && last_vld && (seq == last_seq);
        if (good) begin
            last_seq = seq;
            last_vld = 1'b1;
        end
`endif
        nxt_ack  = arq_en && good;
        nxt_nack = arq_en && !good;
        nxt_drop = !good;
        if (good && !dup) begin
            stored++;
            for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), pay[31-8*i -: 8]});
        end
        step(8'h00, 1'b0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(8'h00, 1'b0);
        chk("drain_left", exp_q.size(), 0);
        idle(3);
    endtask

    task automatic counts(input string tag, input int da, input int dn, input int dd, input int db);
        chk({tag, "_acks"}, ack_cnt - b_ack, da);
        chk({tag, "_nacks"}, nack_cnt - b_nack, dn);
        chk({tag, "_drops"}, drop_cnt - b_drop, dd);
        chk({tag, "_bytes"}, byte_cnt - b_byte, db);
        b_ack  = ack_cnt;
        b_nack = nack_cnt;
        b_drop = drop_cnt;
        b_byte = byte_cnt;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_nack"}, nack, 0);
        chk({tag, "_drop"}, drop, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_valid"}, fvalid, 0);
        chk({tag, "_last"}, flast, 0);
        chk({tag, "_data"}, fdata, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx_valid = 1'b0;
        {nxt_locked, nxt_ack, nxt_nack, nxt_drop} = '0;
        {exp_locked, exp_ack, exp_nack, exp_drop} = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        stored = 0;
        drained = 0;
        last_vld = 1'b0;
        @(negedge clk);
        check_zero("rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; arq_en = 1'b1; fready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("init");
        chk_en = 1'b1;

        send_frame(8'h01, 32'h11223344, 8'h45, 0);
        wait_drain();
        counts("good", 1, 0, 0, 4);
        chk("good_b0", out_log[0], 8'h11);
        chk("good_b1", out_log[1], 8'h22);
        chk("good_b2", out_log[2], 8'h33);
        chk("good_b3", out_log[3], 8'h44);
        chk("good_lasts", last_cnt, 1);

        send_frame(8'h01, 32'h11223344, 8'h46, 0);
        idle(6);
        counts("badpar", 0, 1, 1, 0);

        arq_en = 1'b0;
        send_frame(8'h01, 32'h11223344, 8'h46, 0);
        idle(6);
        counts("noarq", 0, 0, 1, 0);
        arq_en = 1'b1;

        fready = 1'b0;
        send_frame(8'h03, 32'hA0A1A2A3, par_of(8'h03, 32'hA0A1A2A3), 0);
        send_frame(8'h04, 32'hB0B1B2B3, par_of(8'h04, 32'hB0B1B2B3), 0);
        send_frame(8'h05, 32'hC0C1C2C3, par_of(8'h05, 32'hC0C1C2C3), 0);
        idle(4);
        counts("ovf", 2, 1, 1, 0);
        fready = 1'b1;
        wait_drain();
        counts("ovf_drain", 0, 0, 0, 8);

        gap_ctr = 0;
        put(8'hF6, 1); put(8'hF6, 1); put(8'h28, 1); put(8'h00, 1);
        send_frame(8'h06, 32'hA1B2C3D4, par_of(8'h06, 32'hA1B2C3D4), 1);
        send_frame(8'hF6, 32'hF6F62828, 8'h28, 1);
        send_frame(8'h07, 32'hC0FFEE11, par_of(8'h07, 32'hC0FFEE11), 1);
        wait_drain();
        counts("robust", 2, 1, 1, 8);

        send_fas(0);
        put(8'h08, 0); put(8'h55, 0); put(8'h66, 0);
        do_reset();
        send_frame(8'h09, 32'h12345678, par_of(8'h09, 32'h12345678), 0);
        wait_drain();
        counts("post_reset", 1, 0, 0, 4);

        send_frame(8'h01, 32'h11223344, 8'h45, 0);
        send_frame(8'h01, 32'h11223344, 8'h45, 0);
        wait_drain();
`ifdef REC_TRAN_DUP_DROP_EN
        counts("dup", 2, 0, 0, 4);
`else
        counts("dup", 2, 0, 0, 8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
